// File: rtl/argmax_layer.sv
// Per-row argmax over an N x CHAR_NUM matrix of signed logits.
// One column is scanned per cycle, and all rows are compared in parallel.
module argmax_layer #(
  parameter int N        = 10,
  parameter int CHAR_NUM = 200,
  parameter int N_LEN    = 16,
  parameter int CHAR_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [N*CHAR_NUM*N_LEN-1:0]  d,
  output logic                         valid,
  output logic [N*CHAR_LEN-1:0]        q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CHAR_LEN-1:0] LAST_COL = CHAR_LEN'(CHAR_NUM - 1);

  logic [1:0]                 state_q, state_d;
  logic [CHAR_LEN-1:0]        col_q, col_d;
  logic signed [N_LEN-1:0]    max_q [N];
  logic signed [N_LEN-1:0]    max_d [N];
  logic [CHAR_LEN-1:0]        idx_q [N];
  logic [CHAR_LEN-1:0]        idx_d [N];
  logic [N*CHAR_LEN-1:0]      q_q, q_d;
  logic signed [N_LEN-1:0]    first_col [N];
  logic signed [N_LEN-1:0]    cur_col [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      first_col[i] = $signed(d[i*CHAR_NUM*N_LEN +: N_LEN]);
      cur_col[i]   = $signed(d[(i*CHAR_NUM + int'(col_q))*N_LEN +: N_LEN]);
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    q_d     = q_q;
    for (int i = 0; i < N; i++) begin
      max_d[i] = max_q[i];
      idx_d[i] = idx_q[i];
    end

    if (!run) begin
      // Dropping run aborts any scan; q keeps the last completed result.
      state_d = S_IDLE;
      col_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          for (int i = 0; i < N; i++) begin
            max_d[i] = first_col[i];
            idx_d[i] = '0;
          end
          col_d   = CHAR_LEN'(1);
          state_d = S_SCAN;
        end
        S_SCAN: begin
          // Strict compare so the lowest index wins among equal maxima.
          for (int i = 0; i < N; i++) begin
            if (cur_col[i] > max_q[i]) begin
              max_d[i] = cur_col[i];
              idx_d[i] = col_q;
            end
          end
          if (col_q == LAST_COL) begin
            for (int i = 0; i < N; i++) begin
              q_d[i*CHAR_LEN +: CHAR_LEN] = idx_d[i];
            end
            col_d   = '0;
            state_d = S_DONE;
          end else begin
            col_d = col_q + CHAR_LEN'(1);
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          col_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      q_q     <= '0;
      for (int i = 0; i < N; i++) begin
        max_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      q_q     <= q_d;
      for (int i = 0; i < N; i++) begin
        max_q[i] <= max_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign valid = run & (state_q == S_DONE);
  assign q     = q_q;

endmodule

// File: tb/tb_argmax_layer.sv
// Directed bench for argmax_layer: hand-computed row indices and scan latency.
module tb_argmax_layer;

  localparam int N        = 10;
  localparam int CHAR_NUM = 200;
  localparam int N_LEN    = 16;
  localparam int CHAR_LEN = 8;

  logic                        clk;
  logic                        rst_n;
  logic                        run;
  logic [N*CHAR_NUM*N_LEN-1:0] d;
  logic                        valid;
  logic [N*CHAR_LEN-1:0]       q;

  int checks;
  int failures;
  int exp_idx [N];
  logic [N*CHAR_LEN-1:0] exp_q;
  logic [N*CHAR_LEN-1:0] prev_q;

  argmax_layer #(
    .N(N), .CHAR_NUM(CHAR_NUM), .N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .d(d), .valid(valid), .q(q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_elem(input int i, input int j, input logic [N_LEN-1:0] v);
    d[(i*CHAR_NUM + j)*N_LEN +: N_LEN] = v;
  endtask

  task automatic fill(input logic [N_LEN-1:0] v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CHAR_NUM; j++)
        set_elem(i, j, v);
  endtask

  task automatic build_exp();
    for (int i = 0; i < N; i++)
      exp_q[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(exp_idx[i]);
  endtask

  // Raise run and count edges until valid; q must hold prev_q until then.
  task automatic run_and_wait(input string tag);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    run = 1'b1;
    do begin
      tick();
      n++;
      if (!valid && q !== prev_q) bad++;
    end while (!valid && n < 400);
    check({tag, "_latency"}, 128'(n), 128'(200));
    check({tag, "_q_held_during_scan"}, 128'(bad), 128'(0));
  endtask

  task automatic drop_run(input string tag);
    run = 1'b0;
    #1;
    check({tag, "_valid_drop_comb"}, 128'(valid), 128'(1'b0));
    tick();
    check({tag, "_valid_idle"}, 128'(valid), 128'(1'b0));
    check({tag, "_q_retained"}, 128'(q), 128'(prev_q));
  endtask

  initial begin
    int bad;
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b1;
    run      = 1'b0;
    d        = '0;
    prev_q   = '0;
    exp_q    = '0;

    // Reset and idle
    #3 rst_n = 1'b0;
    #1;
    check("reset_valid", 128'(valid), 128'(1'b0));
    check("reset_q", 128'(q), 128'(0));
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_valid", 128'(valid), 128'(1'b0));
      check("idle_q", 128'(q), 128'(0));
    end

    // Basic argmax: one 0x0100 peak per row at column 17*i+3
    fill(16'h0000);
    for (int i = 0; i < N; i++) begin
      set_elem(i, 17*i + 3, 16'h0100);
      exp_idx[i] = 17*i + 3;
    end
    build_exp();
    run_and_wait("basic");
    check("basic_q", 128'(q), 128'(exp_q));
    check("basic_row9", 128'(q[9*CHAR_LEN +: CHAR_LEN]), 128'(156));
    prev_q = exp_q;

    // Hold in DONE for 20 cycles, then release
    for (int c = 0; c < 20; c++) begin
      tick();
      check("hold_valid", 128'(valid), 128'(1'b1));
      check("hold_q", 128'(q), 128'(exp_q));
    end
    drop_run("release");

    // Signed and boundary handling
    fill(16'h0000);
    for (int j = 0; j < CHAR_NUM; j++) begin
      set_elem(0, j, 16'hFF00);
      set_elem(1, j, 16'h8000);
      set_elem(3, j, 16'h8000);
      set_elem(4, j, 16'h8000);
    end
    set_elem(0, 199, 16'hFFFF);
    set_elem(1, 0, 16'h7FFF);
    set_elem(2, 5, 16'h0200);
    set_elem(2, 120, 16'h0200);
    set_elem(4, 198, 16'h8001);
    for (int i = 5; i < N; i++) set_elem(i, i*10, 16'h0001);
    exp_idx[0] = 199;
    exp_idx[1] = 0;
    exp_idx[2] = 5;
    exp_idx[3] = 0;
    exp_idx[4] = 198;
    exp_idx[5] = 50;
    exp_idx[6] = 60;
    exp_idx[7] = 70;
    exp_idx[8] = 80;
    exp_idx[9] = 90;
    build_exp();
    run_and_wait("signed");
    check("signed_q", 128'(q), 128'(exp_q));
    check("signed_tie_row2", 128'(q[2*CHAR_LEN +: CHAR_LEN]), 128'(5));
    prev_q = exp_q;
    drop_run("signed_release");

    // Abort at edge 50 with early large peaks, then restart on new data
    fill(16'h0000);
    for (int i = 0; i < N; i++) set_elem(i, i, 16'h7000);
    run = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (valid !== 1'b0 || q !== prev_q) bad++;
    end
    check("abort_scan_quiet", 128'(bad), 128'(0));
    drop_run("abort");
    fill(16'h0000);
    for (int i = 0; i < N; i++) begin
      set_elem(i, 150 + i, 16'h0010);
      exp_idx[i] = 150 + i;
    end
    build_exp();
    run_and_wait("restart");
    check("restart_q", 128'(q), 128'(exp_q));
    prev_q = exp_q;
    drop_run("restart_release");

    // Async reset at scan column 120, then a full clean scan
    fill(16'hFFFF);
    for (int i = 0; i < N; i++) begin
      set_elem(i, 199 - 7*i, 16'h0000);
      exp_idx[i] = 199 - 7*i;
    end
    build_exp();
    run = 1'b1;
    for (int c = 0; c < 120; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(valid), 128'(1'b0));
    check("async_rst_q", 128'(q), 128'(0));
    #2 rst_n = 1'b1;
    prev_q = '0;
    run_and_wait("post_reset");
    check("post_reset_q", 128'(q), 128'(exp_q));
    check("post_reset_row9", 128'(q[9*CHAR_LEN +: CHAR_LEN]), 128'(136));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argmax_layer.md
Name: argmax_layer

Overview:
- Downstream neighbour of the dense output layer.
- Consumes the flattened N x CHAR_NUM matrix of signed fixed-point logits and produces, per row, the column index of the maximum logit, i.e. the predicted character ID for each of the N positions.
- Scans one column per cycle across all N rows in parallel.
- Uses the codebase's level run/valid handshake, so the dense layer's valid drives this block's run directly.

Parameters:
- N, 10, number of rows (sequence positions).
- CHAR_NUM, 200, number of logits per row (vocabulary size).
- N_LEN, 16, logit width; signed two's complement fixed point.
- CHAR_LEN, 8, index width; must satisfy 2^CHAR_LEN >= CHAR_NUM.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level request; held high while d is stable; low returns block to idle.
- d  input  N*CHAR_NUM*N_LEN  logits; element (i,j) at bits [(i*CHAR_NUM+j)*N_LEN +: N_LEN].
- valid  output  1  result ready; combinational run & (state==DONE).
- q  output  N*CHAR_LEN  argmax index of row i at bits [i*CHAR_LEN +: CHAR_LEN].

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, col=0, all running max and index registers 0, q=0, valid=0.
- State machine has three states: IDLE, SCAN, DONE.
- IDLE, run=1: at the next edge, load max[i]=d(i,0) and idx[i]=0 for all rows, set col=1, go to SCAN. IDLE with run=0 stays in IDLE.
- SCAN, run=1: at each edge, for every row i, if d(i,col) > max[i] (signed, strict), then max[i]<=d(i,col) and idx[i]<=col. col increments by 1 each edge.
- Last column: on the edge that processes col==CHAR_NUM-1, write q with the final indices (including that column's comparison result), reset col to 0, and go to DONE.
- DONE, run=1: hold state; q stable; valid=1.
- run=0 in any state: go to IDLE at the next edge, col cleared to 0. valid drops combinationally in the same cycle. q is not cleared; it retains the last completed result.
- Latency: if run is first sampled high at edge k, state is DONE and valid=1 after edge k+CHAR_NUM-1, i.e. CHAR_NUM edges including k.
- q updates only on the SCAN->DONE transition. During SCAN, q shows the previous result, never partial indices.
- Ties: strict greater-than, so the lowest index among equal maxima wins.
- Signed compare: 0x8000 is the most negative value; 0x7FFF is the most positive.
- Width: col is CHAR_LEN bits and never exceeds CHAR_NUM-1; no wrap-around inside a scan.
- Mid-scan run drop aborts the scan. A new run restarts from column 0 and ignores the partial state.
- Asserting rst_n low during SCAN or DONE forces reset values immediately.
- d must stay stable while run=1. The block does not re-sample changed inputs beyond the current column.
- CHAR_NUM=1 is a degenerate case and is not supported (CHAR_NUM >= 2).

Test Plan:
- Reset and idle: rst_n low, then high with run=0 for 5 cycles -> valid=0 and q=0 throughout.
- Basic argmax: all logits 0x0000 except d(i, 17*i+3)=0x0100 for i=0..9, run held high -> valid rises exactly 200 edges after run is first sampled. q row i = 17*i+3 (row 9 = 156).
- Signed and boundary handling:
  - Row 0: all logits 0xFF00 (negative), d(0,199)=0xFFFF -> index 199.
  - Row 1: d(1,0)=0x7FFF, all others 0x8000 -> index 0.
  - Row 2: d(2,5)=d(2,120)=0x0200, max elsewhere -> index 5 (tie goes to the lower index).
- Abort and restart: drop run at edge 50 of a scan -> valid stays 0 and q keeps the prior result. Load new d and reassert run -> valid again after 200 edges, with q matching the new data only.
- Hold and release: in DONE keep run high for 20 cycles -> q and valid stable. Drop run -> valid=0 in the same cycle, state returns to IDLE, q unchanged.
- Async reset mid-scan: pull rst_n low at scan column 120 between clock edges -> q=0 and valid=0 immediately. After release with run high -> a full 200-edge scan produces the correct result.
